// File: rtl/add_seq_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package add_seq_pkg;

  localparam int NIBW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add4_slice.sv
// Purely combinational nibble adder reused once per cycle by the sequencer.
module add4_slice
  import add_seq_pkg::*;
(
  input  logic [NIBW-1:0] a4,
  input  logic [NIBW-1:0] b4,
  input  logic            cin,
  output logic [NIBW-1:0] s4,
  output logic            cout
);

  assign {cout, s4} = {1'b0, a4} + {1'b0, b4} + {{NIBW{1'b0}}, cin};

endmodule

// File: rtl/add16_seq_ctrl.sv
// Nibble-serial adder: latches operands, runs one add4_slice over NIB cycles LSB first.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module add16_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter  int NIB = 4,
  localparam int W   = NIBW * NIB,
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         co,
  output logic         ovf,
  output logic         busy
);

  state_e                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic                       carry_q, carry_d;
  logic [NIB-1:0][NIBW-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
  logic                       co_q, co_d, ovf_q, ovf_d;
  logic [NIBW-1:0]            sl_s;
  logic                       sl_co;

  add4_slice u_slice (
    .a4   (a_q[idx_q]),
    .b4   (b_q[idx_q]),
    .cin  (carry_q),
    .s4   (sl_s),
    .cout (sl_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          idx_d   = '0;
          s_d     = '0;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d[idx_q] = sl_s;
        carry_d    = sl_co;
        idx_d      = idx_q + IW'(1);
        if (idx_q == IW'(NIB - 1)) begin
          // Final carry leaves through co only; it is never fed back to nibble 0.
          idx_d   = '0;
          co_d    = sl_co;
          ovf_d   = (a_q[NIB-1][NIBW-1] == b_q[NIB-1][NIBW-1]) &&
                    (sl_s[NIBW-1] != a_q[NIB-1][NIBW-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Bench for add16_seq_ctrl: table vectors, random vectors, hold, reset-abort and operand-scramble sequences.
module tb_add16_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, s;
  logic         ci, co, ovf, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  add16_seq_ctrl #(.NIB(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
    logic [W:0] sum;
    logic       v;
    sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc};
    v   = (aa[W-1] == bb[W-1]) && (sum[W-1] != aa[W-1]);
    return {sum[W-1:0], sum[W], v};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s"}, s, 0);
    chk({tag, "_co"}, co, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  // One full transaction; expectation is queued at drive time and popped when out_valid rises.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                        input logic [W+1:0] expv, input bit scramble, input int hold);
    int           cycles;
    logic [W+1:0] e;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    a = aa; b = bb; ci = cc; in_valid = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 0);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    chk("latency", cycles, NIB);
    if (exp_q.size() == 0) begin
      chk("queue_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("sum", s, e[W+1:2]);
      chk("carry_out", co, e[1]);
      chk("overflow", ovf, e[0]);
    end
    repeat (hold) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_sum", s, expv[W+1:2]);
      chk("hold_co", co, expv[1]);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("retire_in_ready", in_ready, 1);
    chk("retire_out_valid", out_valid, 0);
    chk("retire_sum_held", s, expv[W+1:2]);
    chk("retire_co_held", co, expv[1]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, s: 16'h0000, co: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: 16'h1234, b: 16'h4321, ci: 1'b1, s: 16'h5556, co: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 16'h7FFF, b: 16'h0001, ci: 1'b0, s: 16'h8000, co: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 16'h8000, b: 16'h8000, ci: 1'b1, s: 16'h0001, co: 1'b1, ovf: 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, {vecs[i].s, vecs[i].co, vecs[i].ovf}, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, model(ra, rb, rc), 1'b0, 0);
    end

    // Result held under back-pressure with a competing request.
    run_op(16'h1234, 16'h4321, 1'b1, {16'h5556, 1'b0, 1'b0}, 1'b0, 3);

    // Reset mid-operation after two RUN edges.
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    #2;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_result", out_valid, 0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, {16'h0002, 1'b0, 1'b0}, 1'b0, 0);

    // Operands scrambled during RUN must not disturb the latched ones.
    run_op(16'h00FF, 16'h0F0F, 1'b0, {16'h100E, 1'b0, 1'b0}, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
